// File: rtl/logicnet_pkg.sv
`default_nettype none
// ============================================================================
// Module  : logicnet_pkg
// Purpose : Shared definitions for the LogicNet LUT neuron pipeline.
//           - state_t          : table-controller state (clear sweep / run)
//           - DEFAULT_CLR_VAL  : default value written to every table entry
//                                during the post-reset clear sweep
//           - lut_addr_w()     : table address width from neuron geometry
// Revision: 1.0  initial release
// ============================================================================
package logicnet_pkg;

  // Controller state. CLEAR sweeps the table after reset, RUN is the
  // operational state and is only left by reset.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Default clear value for every table entry.
  localparam int unsigned DEFAULT_CLR_VAL = 0;

  // The packed input vector is used directly as the table address, so the
  // address width is the total number of input bits of the neuron.
  function automatic int lut_addr_w(input int fan_in, input int in_bits);
    return fan_in * in_bits;
  endfunction

endpackage : logicnet_pkg
`default_nettype wire

// File: rtl/logicnet_lut_ram.sv
`default_nettype none
// ============================================================================
// Module  : logicnet_lut_ram
// Purpose : Truth-table storage for one neuron. DEPTH x DATA_W distributed
//           RAM with one synchronous write port and two asynchronous read
//           ports (one for the lookup datapath, one for config readback).
//           Contents are not reset; the owner clears them after reset.
// Ports   :
//   clk      in   1        write clock (rising edge)
//   we       in   1        write enable
//   waddr    in   ADDR_W   write address
//   wdata    in   DATA_W   write data
//   raddr_a  in   ADDR_W   read port A address (lookup)
//   rdata_a  out  DATA_W   read port A data, combinational
//   raddr_b  in   ADDR_W   read port B address (config readback)
//   rdata_b  out  DATA_W   read port B data, combinational
// Revision: 1.0  initial release
// ============================================================================
module logicnet_lut_ram
  import logicnet_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

  // Small, wide-fanout table with asynchronous reads: keep it in LUT RAM.
  (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous reads see the contents before any write on the same edge,
  // which gives read-before-write behaviour to registered consumers.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule : logicnet_lut_ram
`default_nettype wire

// File: rtl/logicnet_lut_neuron_pipe.sv
`default_nettype none
// ============================================================================
// Module  : logicnet_lut_neuron_pipe
// Purpose : Pipelined LogicNet neuron. A run-time loadable truth table maps
//           the packed input activations to a quantised output activation
//           under a valid/ready stream handshake. After every reset the table
//           is swept to CLR_VAL (DEPTH cycles, busy high), then the block
//           runs until the next reset.
// Ports   :
//   clk        in   1         clock, rising edge
//   rst_n      in   1         synchronous active-low reset
//   in_valid   in   1         input vector valid
//   in_ready   out  1         input accepted this cycle (registered)
//   in_data    in   ADDR_W    {act[FAN_IN-1],...,act[0]} = table address
//   out_valid  out  1         output activation valid
//   out_ready  in   1         downstream accepts output
//   out_data   out  OUT_BITS  table[in_data], latency 1
//   cfg_we     in   1         table write strobe (ignored while busy)
//   cfg_addr   in   ADDR_W    table write / readback address
//   cfg_wdata  in   OUT_BITS  table write data
//   cfg_rdata  out  OUT_BITS  table[cfg_addr], registered, latency 1
//   busy       out  1         clear sweep in progress
// Revision: 1.0  initial release
// ============================================================================
module logicnet_lut_neuron_pipe
  import logicnet_pkg::*;
#(
  parameter  int          FAN_IN   = 3,
  parameter  int          IN_BITS  = 2,
  parameter  int          OUT_BITS = 2,
  parameter  int unsigned CLR_VAL  = DEFAULT_CLR_VAL,
  localparam int          ADDR_W   = lut_addr_w(FAN_IN, IN_BITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_wdata,
  output logic [OUT_BITS-1:0] cfg_rdata,
  output logic                busy
);

  localparam logic [OUT_BITS-1:0] CLR_WORD = OUT_BITS'(CLR_VAL);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                state;
  state_t                state_d;
  logic [ADDR_W-1:0]     clr_cnt;
  logic                  clr_last;

  logic                  skid_valid;
  logic                  skid_valid_d;
  logic [OUT_BITS-1:0]   skid_data;

  logic                  accept;
  logic                  main_free;

  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_waddr;
  logic [OUT_BITS-1:0]   ram_wdata;
  logic [OUT_BITS-1:0]   lookup_data;
  logic [OUT_BITS-1:0]   cfg_rd;

  // --------------------------------------------------------------------------
  // Table storage
  // --------------------------------------------------------------------------
  // Clear sweep owns the write port while in CLEAR, so config writes are
  // dropped there. Writes are also held off while reset is asserted so a
  // reset cycle never disturbs the table mid-sweep.
  assign clr_last  = &clr_cnt;
  assign ram_we    = rst_n & ((state == ST_CLEAR) | cfg_we);
  assign ram_waddr = (state == ST_CLEAR) ? clr_cnt  : cfg_addr;
  assign ram_wdata = (state == ST_CLEAR) ? CLR_WORD : cfg_wdata;

  logicnet_lut_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (OUT_BITS)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (in_data),
    .rdata_a (lookup_data),
    .raddr_b (cfg_addr),
    .rdata_b (cfg_rd)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    if (state == ST_CLEAR && clr_last) begin
      state_d = ST_RUN;
    end
  end

  // The output register can take a new word when it is empty or draining.
  assign accept    = in_valid & in_ready;
  assign main_free = ~out_valid | out_ready;

  // in_ready is low whenever the skid register is full, so an accept never
  // coincides with a full skid register. When the output register frees up,
  // any skid content moves into it and the skid register empties.
  always_comb begin
    skid_valid_d = skid_valid;
    if (main_free) begin
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_valid_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Sequential logic: controller, clear counter, lookup and skid registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      busy       <= 1'b1;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      cfg_rdata  <= '0;
    end else begin
      state <= state_d;

      // Counter parks on the last address instead of wrapping.
      if (state == ST_CLEAR && !clr_last) begin
        clr_cnt <= clr_cnt + 1'b1;
      end

      busy <= (state_d == ST_CLEAR);

      // Registered ready: derived from next-state values only, so there is
      // no combinational path from out_ready to in_ready.
      in_ready <= (state_d == ST_RUN) & ~skid_valid_d;

      cfg_rdata <= cfg_rd;

      if (main_free) begin
        if (skid_valid) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_data  <= lookup_data;
        end else begin
          out_valid <= 1'b0;
        end
      end

      // Stalled output with a word arriving: park the lookup result.
      if (!main_free && accept) begin
        skid_data <= lookup_data;
      end

      skid_valid <= skid_valid_d;
    end
  end

endmodule : logicnet_lut_neuron_pipe
`default_nettype wire

// File: tb/tb_logicnet_lut_neuron_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_logicnet_lut_neuron_pipe
// Purpose : Self-checking bench for logicnet_lut_neuron_pipe with
//           FAN_IN=3, IN_BITS=2, OUT_BITS=2, CLR_VAL=2'b11 (DEPTH=64).
//           A reference table plus an expected-output queue track every
//           accepted input; hand sequences cover clear, stall, collision
//           and reset corner cases.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_logicnet_lut_neuron_pipe;

  localparam int         DEPTH = 64;
  localparam logic [1:0] CLR   = 2'b11;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic [5:0] in_data   = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_data;
  logic       cfg_we    = 1'b0;
  logic [5:0] cfg_addr  = '0;
  logic [1:0] cfg_wdata = '0;
  logic [1:0] cfg_rdata;
  logic       busy;

  always #5 clk = ~clk;

  logicnet_lut_neuron_pipe #(
    .FAN_IN   (3),
    .IN_BITS  (2),
    .OUT_BITS (2),
    .CLR_VAL  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .busy      (busy)
  );

  int         checks = 0;
  int         errors = 0;
  logic [1:0] model [DEPTH];
  logic [1:0] sb [$];
  bit         model_run = 1'b0;
  int         n_pop = 0;

  typedef struct {
    logic [5:0] addr;
    logic [1:0] load;
    logic [1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare on output transfer, push on input transfer, then
  // update the reference table (lookup sees the pre-write contents).
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got out_data %0h, required no output", out_data);
        end else begin
          check("sb_out_data", {30'd0, out_data}, {30'd0, sb.pop_front()});
          n_pop++;
        end
      end
      if (in_valid && in_ready) sb.push_back(model[in_data]);
      if (cfg_we && model_run) model[cfg_addr] = cfg_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic cfg_read_check(input string name, input logic [5:0] a, input logic [1:0] exp);
    cfg_addr = a;
    tick();
    check(name, {30'd0, cfg_rdata}, {30'd0, exp});
  endtask

  // Count busy cycles after reset release; optionally pulse a config write
  // into address 5 in the middle of the sweep.
  task automatic wait_clear(input bit pulse);
    int cnt = 0;
    bit ok  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (in_ready) ok = 1'b0;
      if (pulse && cnt == 20) begin
        cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = 2'b00;
      end else if (pulse && cnt == 21) begin
        cfg_we = 1'b0;
      end
    end
    cfg_we = 1'b0;
    check("busy_cycles", cnt, 64);
    check("in_ready_low_while_busy", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    model_run = 1'b1;
  endtask

  initial begin
    vec_t vecs [3];
    int   sent;
    int   pop0;

    for (int i = 0; i < DEPTH; i++) model[i] = CLR;

    // ---- 1: reset state, clear duration, cleared contents
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy",      {31'd0, busy},      32'd1);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {30'd0, out_data},  32'd0);
    check("rst_cfg_rdata", {30'd0, cfg_rdata}, 32'd0);
    rst_n = 1'b1;
    wait_clear(1'b0);
    for (int a = 0; a < DEPTH; a++) cfg_read_check("clear_readback", 6'(a), CLR);

    // ---- 2: table-driven back-to-back lookups
    vecs[0] = '{6'h08, 2'b00, 2'b00};
    vecs[1] = '{6'h04, 2'b01, 2'b01};
    vecs[2] = '{6'h24, 2'b10, 2'b10};
    for (int i = 0; i < 3; i++) cfg_write(vecs[i].addr, vecs[i].load);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].addr;
      @(negedge clk);
      check("t2_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("t2_out_valid", {31'd0, out_valid}, 32'd1);
      check("t2_out_data",  {30'd0, out_data},  {30'd0, vecs[i].exp});
    end
    in_valid = 1'b0;
    tick();
    check("t2_drained", {31'd0, out_valid}, 32'd0);

    // ---- 3: 3-cycle downstream stall mid-stream
    for (int i = 0; i < 8; i++) cfg_write(6'(6'h30 + i), 2'(i));
    sent = 0;
    pop0 = n_pop;
    for (int c = 0; c < 60 && sent < 8; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = 1'b1;
      in_data   = 6'(6'h30 + sent);
      @(negedge clk);
      if (c == 3) check("t3_in_ready_stall_start", {31'd0, in_ready}, 32'd1);
      if (c >= 3 && c <= 5) begin
        check("t3_out_valid_held", {31'd0, out_valid}, 32'd1);
        check("t3_out_data_held",  {30'd0, out_data},  32'd2);
      end
      if (c == 4 || c == 5) check("t3_in_ready_dropped", {31'd0, in_ready}, 32'd0);
      if (in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
    check("t3_sent",     sent, 8);
    check("t3_sb_empty", sb.size(), 0);
    check("t3_count",    n_pop - pop0, 8);

    // ---- 4: write/lookup/readback collision on the same address
    cfg_we    = 1'b1;
    cfg_addr  = 6'h10;
    cfg_wdata = 2'b01;
    in_valid  = 1'b1;
    in_data   = 6'h10;
    tick();
    cfg_we = 1'b0;
    check("t4_out_valid", {31'd0, out_valid}, 32'd1);
    check("t4_out_old",   {30'd0, out_data},  32'd3);
    check("t4_rdata_old", {30'd0, cfg_rdata}, 32'd3);
    tick();
    in_valid = 1'b0;
    check("t4_out_new",   {30'd0, out_data},  32'd1);
    check("t4_rdata_new", {30'd0, cfg_rdata}, 32'd1);
    tick();

    // ---- 5: reset during RUN with a pending output; 6: write during clear
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 6'h10;
    tick();
    in_valid = 1'b0;
    check("t5_out_valid_before", {31'd0, out_valid}, 32'd1);
    rst_n     = 1'b0;
    model_run = 1'b0;
    sb.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = CLR;
    tick();
    rst_n = 1'b1;
    check("t5_out_valid_after", {31'd0, out_valid}, 32'd0);
    check("t5_busy",            {31'd0, busy},      32'd1);
    check("t5_in_ready",        {31'd0, in_ready},  32'd0);
    out_ready = 1'b1;
    wait_clear(1'b1);
    cfg_read_check("t6_addr5_cleared",  6'd5,  CLR);
    cfg_read_check("t5_addr08_cleared", 6'h08, CLR);
    cfg_read_check("t5_addr24_cleared", 6'h24, CLR);
    cfg_read_check("t5_addr10_cleared", 6'h10, CLR);

    // Short post-reset stream through the scoreboard.
    cfg_write(6'h3f, 2'b10);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = (i % 2 == 0) ? 6'h3f : 6'h05;
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
    check("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_logicnet_lut_neuron_pipe
`default_nettype wire
